// File: rtl/fetch_pc_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues credit-limited requests
// to an in-order variable-latency memory and buffers responses with their PCs.
module fetch_pc_queue #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned QDEPTH    = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        pc_select_i,
  input  logic [31:0] pc_branch_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_src_o
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] LIMIT = QDEPTH[CW:0];

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [31:0]   q_instr_q [QDEPTH];
  logic [31:0]   q_pc_q    [QDEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [31:0] target;
  logic        empty, pop, push, drop, transfer;
  logic [CW:0] used;

  always_comb begin
    target   = {pc_branch_i[31:2], 2'b00};
    empty    = (count_q == '0);
    pop      = !empty && !stall_i && !pc_select_i;
    drop     = imem_rvalid_i && (drop_q != '0);
    push     = imem_rvalid_i && !drop && !pc_select_i;
    // A slot freed by this cycle's pop is already usable, which keeps a
    // 1-cycle memory streaming at one instruction per cycle.
    used     = {1'b0, outst_q} + {1'b0, count_q} - (CW+1)'(pop);
    imem_req_o  = !reset_i && !pc_select_i && (used < LIMIT);
    imem_addr_o = fetch_pc_q;
    transfer = imem_req_o && imem_ready_i;

    outst_d = outst_q + CW'(transfer) - CW'(imem_rvalid_i);

    drop_d = drop_q;
    if (pc_select_i)
      drop_d = outst_q - CW'(imem_rvalid_i);
    else if (drop)
      drop_d = drop_q - CW'(1);

    fetch_pc_d = fetch_pc_q;
    if (pc_select_i)
      fetch_pc_d = target;
    else if (transfer)
      fetch_pc_d = fetch_pc_q + 32'd4;

    resp_pc_d = resp_pc_q;
    if (pc_select_i)
      resp_pc_d = target;
    else if (push)
      resp_pc_d = resp_pc_q + 32'd4;

    count_d = count_q;
    if (pc_select_i)
      count_d = '0;
    else
      count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      if (pc_select_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      q_instr_q[wr_ptr_q] <= imem_rdata_i;
      q_pc_q[wr_ptr_q]    <= resp_pc_q;
    end
  end

  always_comb begin
    instr_valid_o = !empty;
    instruction_o = empty ? NOP_INSTR : q_instr_q[rd_ptr_q];
    pc_o          = empty ? resp_pc_q : q_pc_q[rd_ptr_q];
    pc_src_o      = pc_o + 32'd4;
  end

endmodule

// File: tb/tb_fetch_pc_queue.sv
// Directed bench for fetch_pc_queue with an in-order fixed-latency memory model
// that returns word = address.
module tb_fetch_pc_queue;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        pc_select_i = 1'b0;
  logic [31:0] pc_branch_i = '0;
  logic        stall_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i = 1'b1;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        instr_valid_o;
  logic [31:0] instruction_o;
  logic [31:0] pc_o;
  logic [31:0] pc_src_o;

  int unsigned passed = 0;
  int unsigned total  = 0;
  int          lat    = 1;
  int          cyc    = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t memq[$];

  fetch_pc_queue #(
    .RESET_PC (32'h0000_0000),
    .QDEPTH   (2),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .pc_select_i  (pc_select_i),
    .pc_branch_i  (pc_branch_i),
    .stall_i      (stall_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ready_i (imem_ready_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .instr_valid_o(instr_valid_o),
    .instruction_o(instruction_o),
    .pc_o         (pc_o),
    .pc_src_o     (pc_src_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory model: responses driven just after the edge that starts their cycle.
  always @(posedge clk_i) begin
    #1;
    cyc++;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    if (reset_i) begin
      memq.delete();
    end else if (memq.size() > 0 && memq[0].due == cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = memq[0].addr;
      void'(memq.pop_front());
    end
  end

  always @(negedge clk_i) begin
    mreq_t r;
    if (!reset_i && imem_req_o && imem_ready_i) begin
      r.addr = imem_addr_o;
      r.due  = cyc + lat;
      memq.push_back(r);
    end
  end

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  // Leaves the bench at the start of cycle 0 after reset release.
  task automatic apply_reset();
    reset_i     = 1'b1;
    pc_select_i = 1'b0;
    stall_i     = 1'b0;
    next_cycle();
    next_cycle();
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    next_cycle();
    next_cycle();
    settle();
    total++; if (imem_req_o !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req_o); else passed++;
    total++; if (instr_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", instr_valid_o); else passed++;
    total++; if (instruction_o !== 32'h13) $display("FAIL reset_instr: got %h want 00000013", instruction_o); else passed++;
    total++; if (pc_o !== 32'h0) $display("FAIL reset_pc: got %h want 00000000", pc_o); else passed++;
    total++; if (pc_src_o !== 32'h4) $display("FAIL reset_pc_src: got %h want 00000004", pc_src_o); else passed++;
  endtask

  task automatic test_stream();
    lat = 1;
    apply_reset();
    settle();
    total++; if (imem_req_o !== 1'b1) $display("FAIL stream_req0: got %b want 1", imem_req_o); else passed++;
    total++; if (imem_addr_o !== 32'h0) $display("FAIL stream_addr0: got %h want 00000000", imem_addr_o); else passed++;
    total++; if (instr_valid_o !== 1'b0) $display("FAIL stream_valid_c0: got %b want 0", instr_valid_o); else passed++;
    next_cycle();
    settle();
    total++; if (instr_valid_o !== 1'b0) $display("FAIL stream_valid_c1: got %b want 0", instr_valid_o); else passed++;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      settle();
      total++; if (instr_valid_o !== 1'b1) $display("FAIL stream_valid[%0d]: got %b want 1", i, instr_valid_o); else passed++;
      total++; if (pc_o !== 32'(4 * i)) $display("FAIL stream_pc[%0d]: got %h want %h", i, pc_o, 32'(4 * i)); else passed++;
      total++; if (instruction_o !== 32'(4 * i)) $display("FAIL stream_instr[%0d]: got %h want %h", i, instruction_o, 32'(4 * i)); else passed++;
    end
  endtask

  // Continues from test_stream: cycle 6 holds PC 16 at the head.
  task automatic test_stall();
    next_cycle();
    stall_i = 1'b1;
    for (int s = 0; s < 5; s++) begin
      settle();
      total++; if (imem_req_o !== 1'b0) $display("FAIL stall_req[%0d]: got %b want 0", s, imem_req_o); else passed++;
      total++; if (pc_o !== 32'h10) $display("FAIL stall_pc[%0d]: got %h want 00000010", s, pc_o); else passed++;
      total++; if (instruction_o !== 32'h10) $display("FAIL stall_instr[%0d]: got %h want 00000010", s, instruction_o); else passed++;
      next_cycle();
    end
    stall_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      settle();
      total++; if (instr_valid_o !== 1'b1) $display("FAIL unstall_valid[%0d]: got %b want 1", k, instr_valid_o); else passed++;
      total++; if (pc_o !== 32'(16 + 4 * k)) $display("FAIL unstall_pc[%0d]: got %h want %h", k, pc_o, 32'(16 + 4 * k)); else passed++;
      next_cycle();
    end
  endtask

  // Continues from test_stall in steady streaming: response and pop coincide.
  task automatic test_redirect_same_cycle();
    pc_select_i = 1'b1;
    pc_branch_i = 32'h203;
    settle();
    total++; if (imem_req_o !== 1'b0) $display("FAIL rsc_req_R: got %b want 0", imem_req_o); else passed++;
    next_cycle();
    pc_select_i = 1'b0;
    settle();
    total++; if (instr_valid_o !== 1'b0) $display("FAIL rsc_valid_R1: got %b want 0", instr_valid_o); else passed++;
    total++; if (imem_req_o !== 1'b1) $display("FAIL rsc_req_R1: got %b want 1", imem_req_o); else passed++;
    total++; if (imem_addr_o !== 32'h200) $display("FAIL rsc_addr_R1: got %h want 00000200", imem_addr_o); else passed++;
    next_cycle();
    settle();
    total++; if (instr_valid_o !== 1'b0) $display("FAIL rsc_valid_R2: got %b want 0", instr_valid_o); else passed++;
    next_cycle();
    settle();
    total++; if (instr_valid_o !== 1'b1) $display("FAIL rsc_valid_R3: got %b want 1", instr_valid_o); else passed++;
    total++; if (pc_o !== 32'h200) $display("FAIL rsc_pc_R3: got %h want 00000200", pc_o); else passed++;
    total++; if (instruction_o !== 32'h200) $display("FAIL rsc_instr_R3: got %h want 00000200", instruction_o); else passed++;
    total++; if (pc_src_o !== 32'h204) $display("FAIL rsc_pc_src_R3: got %h want 00000204", pc_src_o); else passed++;
    next_cycle();
    settle();
    total++; if (pc_o !== 32'h204) $display("FAIL rsc_pc_R4: got %h want 00000204", pc_o); else passed++;
  endtask

  task automatic test_redirect_latency();
    int  c;
    bit  seen;
    lat = 3;
    apply_reset();
    next_cycle();
    settle();
    total++; if (imem_addr_o !== 32'h4) $display("FAIL rl_addr_c1: got %h want 00000004", imem_addr_o); else passed++;
    next_cycle();
    pc_select_i = 1'b1;
    pc_branch_i = 32'h100;
    settle();
    total++; if (imem_req_o !== 1'b0) $display("FAIL rl_req_c2: got %b want 0", imem_req_o); else passed++;
    next_cycle();
    pc_select_i = 1'b0;
    settle();
    total++; if (instr_valid_o !== 1'b0) $display("FAIL rl_valid_c3: got %b want 0", instr_valid_o); else passed++;
    next_cycle();
    settle();
    total++; if (imem_req_o !== 1'b1) $display("FAIL rl_req_c4: got %b want 1", imem_req_o); else passed++;
    total++; if (imem_addr_o !== 32'h100) $display("FAIL rl_addr_c4: got %h want 00000100", imem_addr_o); else passed++;
    c = 4;
    seen = 1'b0;
    for (int n = 0; n < 16; n++) begin
      next_cycle();
      c++;
      settle();
      if (instr_valid_o) begin
        seen = 1'b1;
        break;
      end
    end
    total++; if (seen !== 1'b1) $display("FAIL rl_timeout: got no valid within 16 cycles, want valid"); else passed++;
    total++; if (c !== 8) $display("FAIL rl_first_cycle: got %0d want 8", c); else passed++;
    total++; if (pc_o !== 32'h100) $display("FAIL rl_pc: got %h want 00000100", pc_o); else passed++;
    total++; if (instruction_o !== 32'h100) $display("FAIL rl_instr: got %h want 00000100", instruction_o); else passed++;
  endtask

  task automatic test_back_to_back();
    int  c;
    bit  seen;
    lat = 3;
    apply_reset();
    next_cycle();
    next_cycle();
    pc_select_i = 1'b1;
    pc_branch_i = 32'h300;
    next_cycle();
    pc_branch_i = 32'h400;
    settle();
    total++; if (imem_req_o !== 1'b0) $display("FAIL b2b_req_c3: got %b want 0", imem_req_o); else passed++;
    next_cycle();
    pc_select_i = 1'b0;
    settle();
    total++; if (imem_req_o !== 1'b1) $display("FAIL b2b_req_c4: got %b want 1", imem_req_o); else passed++;
    total++; if (imem_addr_o !== 32'h400) $display("FAIL b2b_addr_c4: got %h want 00000400", imem_addr_o); else passed++;
    c = 4;
    seen = 1'b0;
    for (int n = 0; n < 16; n++) begin
      next_cycle();
      c++;
      settle();
      if (instr_valid_o) begin
        seen = 1'b1;
        break;
      end
    end
    total++; if (seen !== 1'b1) $display("FAIL b2b_timeout: got no valid within 16 cycles, want valid"); else passed++;
    total++; if (c !== 8) $display("FAIL b2b_first_cycle: got %0d want 8", c); else passed++;
    total++; if (pc_o !== 32'h400) $display("FAIL b2b_pc: got %h want 00000400", pc_o); else passed++;
  endtask

  task automatic test_async_reset();
    lat = 1;
    apply_reset();
    repeat (4) next_cycle();
    settle();
    total++; if (pc_o !== 32'h8) $display("FAIL ar_pre_pc: got %h want 00000008", pc_o); else passed++;
    next_cycle();
    #1;
    reset_i = 1'b1;
    #1;
    total++; if (instr_valid_o !== 1'b0) $display("FAIL ar_valid: got %b want 0", instr_valid_o); else passed++;
    total++; if (instruction_o !== 32'h13) $display("FAIL ar_instr: got %h want 00000013", instruction_o); else passed++;
    total++; if (pc_o !== 32'h0) $display("FAIL ar_pc: got %h want 00000000", pc_o); else passed++;
    total++; if (pc_src_o !== 32'h4) $display("FAIL ar_pc_src: got %h want 00000004", pc_src_o); else passed++;
    total++; if (imem_req_o !== 1'b0) $display("FAIL ar_req: got %b want 0", imem_req_o); else passed++;
    next_cycle();
    next_cycle();
    reset_i = 1'b0;
    settle();
    total++; if (imem_addr_o !== 32'h0) $display("FAIL ar_restart_addr: got %h want 00000000", imem_addr_o); else passed++;
    next_cycle();
    next_cycle();
    settle();
    total++; if (instr_valid_o !== 1'b1) $display("FAIL ar_restart_valid: got %b want 1", instr_valid_o); else passed++;
    total++; if (pc_o !== 32'h0) $display("FAIL ar_restart_pc: got %h want 00000000", pc_o); else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_same_cycle();
    test_redirect_latency();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
